// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
//   Turns 1-cycle trigger strobes into level pulses of programmable high width,
//   each followed by a guaranteed low gap, so every pulse shows exactly one
//   rising edge downstream. Triggers that cannot start a pulse immediately are
//   queued in a saturating pending counter; a trigger that finds the queue full
//   is dropped and flagged in a sticky overflow bit.
//
// Ports
//   clk      in   1       clock, all state updates on posedge
//   rst      in   1       asynchronous, active-high reset
//   trig     in   1       request strobe; each high cycle requests one pulse
//   width    in   CNT_W   high time in cycles (0 treated as 1), sampled at start
//   gap      in   CNT_W   low time after a pulse (0 treated as 1), sampled when
//                         the high phase ends
//   ovf_clr  in   1       synchronous clear of ovf (a same-cycle drop wins)
//   q        out  1       registered pulse train, high exactly while in HIGH
//   busy     out  1       registered, high while in HIGH or LOW
//   pending  out  PEND_W  triggers accepted but not yet started
//   ovf      out  1       sticky: a trigger was dropped on a full queue
// -----------------------------------------------------------------------------
module pulse_gen #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  gap,
  input  logic              ovf_clr,
  output logic              q,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              q_q, q_d;
  logic              busy_q, busy_d;

  logic              start_trig;  // same-cycle trig starts a pulse directly
  logic              deq;         // a queued request starts a pulse
  logic              enq;         // trig that must be queued
  logic              drop;        // trig lost because the queue is full

  // Phase counter load value: a programmed length of 0 behaves as 1 cycle,
  // and the counter runs length-1 down to 0.
  function automatic logic [CNT_W-1:0] len_to_cnt(input logic [CNT_W-1:0] len);
    len_to_cnt = (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_trig = 1'b0;
    deq        = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          start_trig = 1'b1;
          state_d    = HIGH;
          cnt_d      = len_to_cnt(width);
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = LOW;
          cnt_d   = len_to_cnt(gap);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (pend_q != '0) begin
          // Queued work has priority; a same-cycle trig gets queued instead.
          deq     = 1'b1;
          state_d = HIGH;
          cnt_d   = len_to_cnt(width);
        end else if (trig) begin
          start_trig = 1'b1;
          state_d    = HIGH;
          cnt_d      = len_to_cnt(width);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    enq  = trig && !start_trig;
    drop = 1'b0;
    pend_d = pend_q;
    if (enq && !deq) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (deq && !enq) begin
      pend_d = pend_q - PEND_W'(1);
    end
    // Simultaneous enqueue and dequeue leaves pend_d unchanged.

    ovf_d  = drop | (ovf_q & ~ovf_clr);

    // Outputs are registered copies of the next-state decode.
    q_d    = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_gen
//   Directed bench for pulse_gen (CNT_W=8, PEND_W=2). Each scenario drives a
//   per-cycle trig/ovf_clr pattern, logs the outputs once per cycle, and
//   compares the logs against hand-derived cycle masks.
//   Cycle numbering: "cycle c" is the c-th clock period of a run; inputs set
//   in cycle c are sampled at the edge that ends it, outputs are sampled 1ns
//   after the edge that starts it.
// -----------------------------------------------------------------------------
module tb_pulse_gen;

  localparam int CNT_W  = 8;
  localparam int PEND_W = 2;
  localparam int NCYC   = 128;

  logic              clk;
  logic              rst;
  logic              trig;
  logic [CNT_W-1:0]  width;
  logic [CNT_W-1:0]  gap;
  logic              ovf_clr;
  logic              q;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  pulse_gen #(
    .CNT_W  (CNT_W),
    .PEND_W (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .width   (width),
    .gap     (gap),
    .ovf_clr (ovf_clr),
    .q       (q),
    .busy    (busy),
    .pending (pending),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic              q_log    [NCYC];
  logic              busy_log [NCYC];
  logic              ovf_log  [NCYC];
  logic [PEND_W-1:0] pend_log [NCYC];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits lo..hi set.
  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] q_mask();
    logic [127:0] m;
    for (int i = 0; i < NCYC; i++) m[i] = q_log[i];
    return m;
  endfunction

  function automatic logic [127:0] busy_mask();
    logic [127:0] m;
    for (int i = 0; i < NCYC; i++) m[i] = busy_log[i];
    return m;
  endfunction

  function automatic logic [127:0] pend_nz_mask();
    logic [127:0] m;
    for (int i = 0; i < NCYC; i++) m[i] = (pend_log[i] != '0);
    return m;
  endfunction

  function automatic int max_pend();
    int mx;
    mx = 0;
    for (int i = 0; i < NCYC; i++) if (int'(pend_log[i]) > mx) mx = int'(pend_log[i]);
    return mx;
  endfunction

  function automatic int rise_count();
    int n;
    n = 0;
    for (int i = 1; i < NCYC; i++) if (q_log[i] && !q_log[i-1]) n++;
    return n;
  endfunction

  // Runs NCYC cycles with the given trig/ovf_clr patterns. If rst_cyc >= 0,
  // reset is pulsed asynchronously mid-way through that cycle, the outputs
  // are checked while reset is held, and all later triggers are suppressed.
  task automatic run(input logic [127:0] trig_pat, input logic [127:0] clr_pat,
                     input int rst_cyc);
    bit killed;
    killed = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      q_log[c]    = q;
      busy_log[c] = busy;
      ovf_log[c]  = ovf;
      pend_log[c] = pending;
      trig    = killed ? 1'b0 : trig_pat[c];
      ovf_clr = clr_pat[c];
      if (c == rst_cyc) begin
        #2;
        rst  = 1'b1;
        trig = 1'b0;
        killed = 1'b1;
        #1;
        chk("async_rst_q",    {127'd0, q},       128'd0);
        chk("async_rst_busy", {127'd0, busy},    128'd0);
        chk("async_rst_pend", {126'd0, pending}, 128'd0);
        chk("async_rst_ovf",  {127'd0, ovf},     128'd0);
        #1;
        rst = 1'b0;
      end
    end
    trig    = 1'b0;
    ovf_clr = 1'b0;
  endtask

  logic [127:0] none;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    none    = '0;
    rst     = 1'b1;
    trig    = 1'b0;
    ovf_clr = 1'b0;
    width   = 8'd3;
    gap     = 8'd2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_q",    {127'd0, q},       128'd0);
    chk("rst_hold_busy", {127'd0, busy},    128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_q",    {127'd0, q},       128'd0);
    chk("post_rst_busy", {127'd0, busy},    128'd0);
    chk("post_rst_pend", {126'd0, pending}, 128'd0);
    chk("post_rst_ovf",  {127'd0, ovf},     128'd0);

    // 1: width=3, gap=2, single trigger.
    width = 8'd3; gap = 8'd2;
    run(rng(10, 10), none, -1);
    chk("t1_q",    q_mask(),       rng(11, 13));
    chk("t1_busy", busy_mask(),    rng(11, 15));
    chk("t1_pend", pend_nz_mask(), none);

    // 2: width=0 and gap=0 behave as 1.
    width = 8'd0; gap = 8'd0;
    run(rng(10, 10), none, -1);
    chk("t2_q",    q_mask(),    rng(11, 11));
    chk("t2_busy", busy_mask(), rng(11, 12));

    // 3: back-to-back triggers queue and drain.
    width = 8'd2; gap = 8'd1;
    run(rng(10, 12), none, -1);
    chk("t3_q",       q_mask(),                 rng(11, 12) | rng(14, 15) | rng(17, 18));
    chk("t3_busy",    busy_mask(),              rng(11, 19));
    chk("t3_pend_mx", 128'(max_pend()),         128'd2);
    chk("t3_pend13",  {126'd0, pend_log[13]},   128'd2);
    chk("t3_pend14",  {126'd0, pend_log[14]},   128'd1);
    chk("t3_pend_nz", pend_nz_mask(),           rng(12, 16));

    // 6: trig in the last LOW cycle with an empty queue starts directly.
    width = 8'd2; gap = 8'd3;
    run(rng(10, 10) | rng(15, 15), none, -1);
    chk("t6_q",    q_mask(),       rng(11, 12) | rng(16, 17));
    chk("t6_busy", busy_mask(),    rng(11, 20));
    chk("t6_pend", pend_nz_mask(), none);

    // 4: saturation; ovf_clr in the drop cycle loses, a later one clears.
    width = 8'd8; gap = 8'd1;
    run(rng(10, 14), rng(14, 14) | rng(16, 16), -1);
    chk("t4_pend14", {126'd0, pend_log[14]}, 128'd3);
    chk("t4_pend15", {126'd0, pend_log[15]}, 128'd3);
    chk("t4_ovf14",  {127'd0, ovf_log[14]},  128'd0);
    chk("t4_ovf15",  {127'd0, ovf_log[15]},  128'd1);
    chk("t4_ovf16",  {127'd0, ovf_log[16]},  128'd1);
    chk("t4_ovf17",  {127'd0, ovf_log[17]},  128'd0);
    chk("t4_pulses", 128'(rise_count()),     128'd4);
    chk("t4_q",      q_mask(),
        rng(11, 18) | rng(20, 27) | rng(29, 36) | rng(38, 45));

    // 5: async reset in the middle of pulse 1 of scenario 3 (queue holds 1).
    width = 8'd2; gap = 8'd1;
    run(rng(10, 12), none, 12);
    chk("t5_pend12", {126'd0, pend_log[12]}, 128'd1);
    chk("t5_q",      q_mask(),               rng(11, 12));
    chk("t5_busy",   busy_mask(),            rng(11, 12));
    chk("t5_pend",   pend_nz_mask(),         rng(12, 12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
